// File: rtl/mem_stage_pkg.sv
// Shared definitions for the RV32I MEM stage: widths, op codes, FSM states and
// small op-decoding helpers used by mem_stage and ld_ext.
package mem_stage_pkg;

  localparam int OP_LEN       = 5;
  localparam int ADDR_LEN     = 32;
  localparam int REG_LEN      = 32;
  localparam int REG_ADDR_LEN = 5;

  localparam logic [REG_LEN-1:0]      ZERO_WORD     = '0;
  localparam logic [REG_ADDR_LEN-1:0] REG_ADDR_ZERO = '0;

  typedef enum logic [OP_LEN-1:0] {
    OP_NOP  = 5'd0,
    OP_ADDI = 5'd1,
    OP_ADD  = 5'd2,
    OP_BEQ  = 5'd3,
    OP_LB   = 5'd8,
    OP_LH   = 5'd9,
    OP_LW   = 5'd10,
    OP_LBU  = 5'd11,
    OP_LHU  = 5'd12,
    OP_SB   = 5'd16,
    OP_SH   = 5'd17,
    OP_SW   = 5'd18
  } op_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_RD   = 2'd1,
    MEM_WR   = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_e;

  function automatic logic is_load(input logic [OP_LEN-1:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [OP_LEN-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [2:0] byte_count(input logic [OP_LEN-1:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      OP_LW, OP_SW:         return 3'd4;
      default:              return 3'd1;
    endcase
  endfunction

  // Halfwords need bit 0 clear, words need bits 1:0 clear.
  function automatic logic is_misaligned(input logic [OP_LEN-1:0] op,
                                         input logic [1:0] addr_lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return addr_lo[0];
      OP_LW, OP_SW:         return addr_lo != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ld_ext.sv
// Load extension: turns the assembled little-endian bytes into the register
// value, sign-extending LB/LH and zero-extending LBU/LHU.
module ld_ext
  import mem_stage_pkg::*;
(
  input  logic [OP_LEN-1:0]  op,
  input  logic [REG_LEN-1:0] raw,
  output logic [REG_LEN-1:0] value
);

  always_comb begin
    case (op)
      OP_LB:   value = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   value = {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  value = {24'h0, raw[7:0]};
      OP_LHU:  value = {16'h0, raw[15:0]};
      default: value = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: byte-serial loads/stores over a synchronous 8-bit RAM port.
// Define MEM_MISALIGN_CHK_EN to trap misaligned halfword/word accesses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OP_LEN-1:0]       op_i,
  input  logic [ADDR_LEN-1:0]     addr_i,
  input  logic [REG_LEN-1:0]      data_i,
  input  logic [REG_ADDR_LEN-1:0] rd_i,
  input  logic [BYTE_W-1:0]       mem_din,
  output logic [BYTE_W-1:0]       mem_dout,
  output logic [ADDR_LEN-1:0]     mem_a,
  output logic                    mem_wr,
  output logic                    mem_req,
  output logic [REG_LEN-1:0]      wb_data,
  output logic [REG_ADDR_LEN-1:0] wb_addr,
  output logic                    mem_stall,
  output logic                    misalign
);

  mem_state_e          state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_m1;
  logic [CNT_W-1:0]    n_bytes;
  logic [REG_LEN-1:0]  ld_bytes;
  logic [REG_LEN-1:0]  ext_val;
  logic [ADDR_LEN-1:0] cnt_addr;
  logic                is_ld;
  logic                is_st;
  logic                mis_now;
  logic                misalign_q;

  assign is_ld    = is_load(op_i);
  assign is_st    = is_store(op_i);
  assign n_bytes  = CNT_W'(byte_count(op_i));
  assign cnt_m1   = cnt - CNT_W'(1);
  assign cnt_addr = addr_i + ADDR_LEN'(cnt);
  assign misalign = misalign_q;

`ifdef MEM_MISALIGN_CHK_EN
  assign mis_now = is_misaligned(op_i, addr_i[1:0]);
`else
  assign mis_now = 1'b0;
`endif

  ld_ext u_ld_ext (
    .op    (op_i),
    .raw   (ld_bytes),
    .value (ext_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MEM_IDLE;
      cnt        <= '0;
      ld_bytes   <= '0;
      misalign_q <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          misalign_q <= 1'b0;
          if (is_ld || is_st) begin
            ld_bytes <= '0;
            if (mis_now) begin
              state      <= MEM_DONE;
              misalign_q <= 1'b1;
            end else if (is_ld) begin
              state <= MEM_RD;
              cnt   <= CNT_W'(1);
            end else if (n_bytes == CNT_W'(1)) begin
              state <= MEM_DONE;
            end else begin
              state <= MEM_WR;
              cnt   <= CNT_W'(1);
            end
          end
        end
        // Byte cnt-1 arrives now because its address went out last cycle.
        MEM_RD: begin
          ld_bytes[{cnt_m1[1:0], 3'b000} +: 8] <= mem_din;
          if (cnt < n_bytes) cnt <= cnt + CNT_W'(1);
          else               state <= MEM_DONE;
        end
        MEM_WR: begin
          if (cnt == n_bytes - CNT_W'(1)) state <= MEM_DONE;
          else                            cnt   <= cnt + CNT_W'(1);
        end
        MEM_DONE: begin
          state      <= MEM_IDLE;
          cnt        <= '0;
          misalign_q <= 1'b0;
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

  // The RAM samples address/write at the edge that ends each cycle, so the
  // port is driven combinationally from the current state and byte count.
  always_comb begin
    mem_a     = '0;
    mem_dout  = '0;
    mem_wr    = 1'b0;
    mem_req   = 1'b0;
    mem_stall = 1'b0;
    wb_data   = data_i;
    wb_addr   = REG_ADDR_ZERO;
    case (state)
      MEM_IDLE: begin
        if (is_ld || is_st) begin
          mem_stall = 1'b1;
          if (!mis_now) begin
            mem_req = 1'b1;
            mem_a   = addr_i;
            if (is_st) begin
              mem_wr   = 1'b1;
              mem_dout = data_i[7:0];
            end
          end
        end else begin
          wb_addr = rd_i;
        end
      end
      MEM_RD: begin
        mem_req   = 1'b1;
        mem_stall = 1'b1;
        if (cnt < n_bytes) mem_a = cnt_addr;
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_stall = 1'b1;
        mem_wr    = 1'b1;
        mem_a     = cnt_addr;
        mem_dout  = data_i[{cnt[1:0], 3'b000} +: 8];
      end
      MEM_DONE: begin
        mem_req = !misalign_q;
        if (misalign_q) begin
          wb_data = ZERO_WORD;
        end else if (is_ld) begin
          wb_data = ext_val;
          wb_addr = rd_i;
        end
      end
      default: ;
    endcase
    // Reset kills any write in flight so an aborted store leaves only the
    // bytes already committed.
    if (rst) begin
      mem_a     = '0;
      mem_dout  = '0;
      mem_wr    = 1'b0;
      mem_req   = 1'b0;
      mem_stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a byte-wide synchronous RAM
// model; the misaligned-access test follows MEM_MISALIGN_CHK_EN.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  op_i = OP_NOP;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [4:0]  rd_i = '0;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        mem_req;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        mem_stall;
  logic        misalign;

  int checks = 0;
  int failures = 0;

  logic [7:0]  ram [logic [31:0]];
  logic [31:0] wr_log_a [$];
  logic [7:0]  wr_log_d [$];

  int          r_stall, r_wr, r_req;
  logic        r_done_req, r_mis;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_addr;

  mem_stage dut (
    .clk(clk), .rst(rst), .op_i(op_i), .addr_i(addr_i), .data_i(data_i),
    .rd_i(rd_i), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .mem_req(mem_req), .wb_data(wb_data), .wb_addr(wb_addr),
    .mem_stall(mem_stall), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (ram.exists(mem_a)) mem_din <= ram[mem_a];
    else                   mem_din <= 8'h00;
    if (mem_wr) begin
      ram[mem_a] = mem_dout;
      wr_log_a.push_back(mem_a);
      wr_log_d.push_back(mem_dout);
    end
  end

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 8'hxx;
  endfunction

  task automatic run_op(input logic [4:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd);
    int n;
    @(negedge clk);
    op_i = op; addr_i = addr; data_i = data; rd_i = rd;
    #1;
    r_stall = 0; r_wr = 0; r_req = 0; n = 0;
    while (mem_stall === 1'b1 && n < 50) begin
      r_stall++;
      if (mem_wr === 1'b1) r_wr++;
      if (mem_req === 1'b1) r_req++;
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 50) begin failures++; $display("[TB] FAIL timeout op=%0d stall never dropped", op); end
    r_done_req = mem_req; r_wb_data = wb_data; r_wb_addr = wb_addr; r_mis = misalign;
    @(negedge clk);
    op_i = OP_NOP; addr_i = '0; data_i = '0; rd_i = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    op_i = OP_SW; addr_i = 32'h40; data_i = 32'hFFFF_FFFF;
    #1;
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_wr got=%b exp=0", mem_wr); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_a !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_a got=%h exp=0", mem_a); end
    checks++; if (mem_dout !== 8'h0) begin failures++; $display("[TB] FAIL reset_mem_dout got=%h exp=0", mem_dout); end
    checks++; if (misalign !== 1'b0) begin failures++; $display("[TB] FAIL reset_misalign got=%b exp=0", misalign); end
    op_i = OP_NOP; addr_i = '0; data_i = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_stall got=%b exp=0", mem_stall); end
  endtask

  task automatic test_alu_pass();
    @(negedge clk);
    op_i = OP_ADDI; data_i = 32'h5; rd_i = 5'd3;
    #1;
    checks++; if (wb_data !== 32'h5) begin failures++; $display("[TB] FAIL alu_wb_data got=%h exp=5", wb_data); end
    checks++; if (wb_addr !== 5'd3) begin failures++; $display("[TB] FAIL alu_wb_addr got=%0d exp=3", wb_addr); end
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("[TB] FAIL alu_stall got=%b exp=0", mem_stall); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL alu_req got=%b exp=0", mem_req); end
    op_i = OP_NOP; data_i = '0; rd_i = '0;
  endtask

  task automatic test_lw();
    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    run_op(OP_LW, 32'h100, 32'h0, 5'd7);
    checks++; if (r_stall != 5) begin failures++; $display("[TB] FAIL lw_stall got=%0d exp=5", r_stall); end
    checks++; if (r_wb_data !== 32'h1234_5678) begin failures++; $display("[TB] FAIL lw_data got=%h exp=12345678", r_wb_data); end
    checks++; if (r_wb_addr !== 5'd7) begin failures++; $display("[TB] FAIL lw_wb_addr got=%0d exp=7", r_wb_addr); end
    checks++; if (r_wr != 0) begin failures++; $display("[TB] FAIL lw_no_write got=%0d exp=0", r_wr); end
    checks++; if (r_req != 5 || r_done_req !== 1'b1) begin failures++; $display("[TB] FAIL lw_req got=%0d/%b exp=5/1", r_req, r_done_req); end
  endtask

  task automatic test_narrow_loads();
    logic [4:0]  ops [4]  = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
    logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FF80, 32'h0000_FF80};
    int          stalls [4] = '{2, 2, 3, 3};
    ram[32'h200] = 8'h80; ram[32'h201] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'h200, 32'h0, 5'd5);
      checks++; if (r_wb_data !== exps[i]) begin failures++; $display("[TB] FAIL load_ext[%0d] got=%h exp=%h", i, r_wb_data, exps[i]); end
      checks++; if (r_stall != stalls[i]) begin failures++; $display("[TB] FAIL load_stall[%0d] got=%0d exp=%0d", i, r_stall, stalls[i]); end
    end
  endtask

  task automatic test_stores();
    wr_log_a.delete(); wr_log_d.delete();
    run_op(OP_SW, 32'h300, 32'hA1B2_C3D4, 5'd9);
    checks++; if (r_wr != 4 || r_stall != 4) begin failures++; $display("[TB] FAIL sw_cycles got=%0d/%0d exp=4/4", r_wr, r_stall); end
    checks++; if (r_wb_addr !== 5'd0) begin failures++; $display("[TB] FAIL sw_wb_addr got=%0d exp=0", r_wb_addr); end
    checks++;
    if ({ram_byte(32'h303), ram_byte(32'h302), ram_byte(32'h301), ram_byte(32'h300)} !== 32'hA1B2_C3D4) begin
      failures++;
      $display("[TB] FAIL sw_bytes got=%h %h %h %h exp=d4 c3 b2 a1", ram_byte(32'h300), ram_byte(32'h301), ram_byte(32'h302), ram_byte(32'h303));
    end
    run_op(OP_SB, 32'h310, 32'h0000_0055, 5'd1);
    checks++; if (r_stall != 1 || ram_byte(32'h310) !== 8'h55) begin failures++; $display("[TB] FAIL sb got=%0d/%h exp=1/55", r_stall, ram_byte(32'h310)); end
    run_op(OP_SH, 32'h320, 32'h1234_BEEF, 5'd1);
    checks++;
    if (r_stall != 2 || ram_byte(32'h320) !== 8'hEF || ram_byte(32'h321) !== 8'hBE || ram.exists(32'h322)) begin
      failures++;
      $display("[TB] FAIL sh got=%0d/%h %h exp=2/ef be", r_stall, ram_byte(32'h320), ram_byte(32'h321));
    end
  endtask

  task automatic test_load_rd0();
    run_op(OP_LB, 32'h200, 32'h0, 5'd0);
    checks++; if (r_stall != 2 || r_wb_addr !== 5'd0) begin failures++; $display("[TB] FAIL rd0_load got=%0d/%0d exp=2/0", r_stall, r_wb_addr); end
  endtask

  task automatic test_wrap_and_reset();
    wr_log_a.delete(); wr_log_d.delete();
    run_op(OP_SW, 32'hFFFF_FFFE, 32'h5566_7788, 5'd0);
    checks++;
    if (wr_log_a.size() != 4 || wr_log_a[0] !== 32'hFFFF_FFFE || wr_log_a[1] !== 32'hFFFF_FFFF ||
        wr_log_a[2] !== 32'h0 || wr_log_a[3] !== 32'h1) begin
      failures++;
      $display("[TB] FAIL wrap_addrs got=%0d writes exp=FFFFFFFE FFFFFFFF 0 1", wr_log_a.size());
    end
    checks++; if (ram_byte(32'h0) !== 8'h66 || ram_byte(32'h1) !== 8'h55) begin failures++; $display("[TB] FAIL wrap_bytes got=%h %h exp=66 55", ram_byte(32'h0), ram_byte(32'h1)); end
    ram.delete();
    wr_log_a.delete(); wr_log_d.delete();
    @(negedge clk);
    op_i = OP_SW; addr_i = 32'hFFFF_FFFE; data_i = 32'h1122_3344;
    @(negedge clk); #1;
    checks++; if (mem_a !== 32'hFFFF_FFFF || mem_wr !== 1'b1) begin failures++; $display("[TB] FAIL wrap_byte1 got=%h/%b exp=ffffffff/1", mem_a, mem_wr); end
    rst = 1'b1; op_i = OP_NOP; addr_i = '0; data_i = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (mem_stall !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("[TB] FAIL abort_idle got=%b/%b exp=0/0", mem_stall, mem_req); end
    checks++;
    if (wr_log_a.size() != 1 || ram_byte(32'hFFFF_FFFE) !== 8'h44 || ram.exists(32'hFFFF_FFFF)) begin
      failures++;
      $display("[TB] FAIL abort_writes got=%0d writes exp=1 (44 at FFFFFFFE)", wr_log_a.size());
    end
  endtask

  task automatic test_misaligned();
    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12; ram[32'h104] = 8'h9A;
    run_op(OP_LW, 32'h101, 32'h0, 5'd4);
`ifdef MEM_MISALIGN_CHK_EN
    checks++; if (r_stall != 1 || r_req != 0) begin failures++; $display("[TB] FAIL mis_stall got=%0d/%0d exp=1/0", r_stall, r_req); end
    checks++; if (r_mis !== 1'b1) begin failures++; $display("[TB] FAIL mis_pulse got=%b exp=1", r_mis); end
    checks++; if (r_wb_addr !== 5'd0 || r_wb_data !== 32'h0) begin failures++; $display("[TB] FAIL mis_wb got=%0d/%h exp=0/0", r_wb_addr, r_wb_data); end
`else
    checks++; if (r_stall != 5) begin failures++; $display("[TB] FAIL mis_stall got=%0d exp=5", r_stall); end
    checks++; if (r_mis !== 1'b0) begin failures++; $display("[TB] FAIL mis_pulse got=%b exp=0", r_mis); end
    checks++; if (r_wb_data !== 32'h9A12_3456 || r_wb_addr !== 5'd4) begin failures++; $display("[TB] FAIL mis_wb got=%h/%0d exp=9a123456/4", r_wb_data, r_wb_addr); end
`endif
  endtask

  initial begin
    $display("[TB] mem_stage directed tests");
    test_reset();
    test_alu_pass();
    test_lw();
    test_narrow_loads();
    test_stores();
    test_load_rd0();
    test_wrap_and_reset();
    test_misaligned();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
